alu_arbiter: RTL and testbench

//  Shares one combinational ALU (alu_file) between NREQ requesters (e.g. execute stage, branch/debug unit).
//  Per-requester req/ack handshake; a 3-state FSM registers the winner's operands, drives the ALU
//  for one cycle and returns the registered result and flags. Sits between the requesters and alu_file.

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_if.sv | 31 +++
 rtl/alu_arbiter_rr_picker.sv | 54 +++++
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice.
//   aluop_t     : 4-bit ALU operation codes understood by alu_file
//   arb_state_t : arbiter FSM states (IDLE -> EXEC -> RESP)
//   idx_w()     : width of a requester index for a given requester count
package alu_arbiter_pkg;

    localparam int ALUOP_W = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter.
//   req_i/op_i/a_i/b_i : per-requester request, op code and operands
//   ack_o              : one-hot, one-cycle completion strobe
//   result_o, zero_o, negative_o, overflow_o : registered ALU result and flags
//   busy_o             : arbiter is executing or responding
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int WORD_W = 32
);
    logic [NREQ-1:0]             req_i;
    logic [NREQ-1:0][3:0]        op_i;
    logic [NREQ-1:0][WORD_W-1:0] a_i;
    logic [NREQ-1:0][WORD_W-1:0] b_i;
    logic [NREQ-1:0]             ack_o;
    logic [WORD_W-1:0]           result_o;
    logic                        zero_o;
    logic                        negative_o;
    logic                        overflow_o;
    logic                        busy_o;

    modport master (
        output req_i, op_i, a_i, b_i,
        input  ack_o, result_o, zero_o, negative_o, overflow_o, busy_o
    );

    modport slave (
        input  req_i, op_i, a_i, b_i,
        output ack_o, result_o, zero_o, negative_o, overflow_o, busy_o
    );
endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational winner selection for the ALU arbiter.
// Build option: ALU_ARB_ROUNDROBIN_EN
//   defined   : round-robin, search starts at (ptr_i+1) mod NREQ and wraps
//   undefined : fixed priority, lowest index wins; no pointer port
// Ports:
//   req_i   : request vector
//   ptr_i   : last granted index (round-robin build only)
//   grant_o : one-hot grant (all zero when no request)
//   idx_o   : index of the granted requester
module alu_arbiter_rr_picker
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = idx_w(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
`ifdef ALU_ARB_ROUNDROBIN_EN
    input  logic [IDX_W-1:0] ptr_i,
`endif
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        cand    = '0;
        found   = 1'b0;
`ifdef ALU_ARB_ROUNDROBIN_EN
        // Offsets 1..NREQ visit every requester once, the last granted one last.
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % NREQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            cand = IDX_W'(i);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
`endif
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU (alu_file) between NREQ requesters.
// IDLE latches the winner's op/operands, EXEC drives the ALU from those latched
// values and captures its result/flags, RESP pulses the winner's ack.
// Build option: ALU_ARB_ROUNDROBIN_EN selects round-robin instead of fixed priority.
// Ports:
//   CLK, nRST       : clock (rising edge), asynchronous active-low reset
//   bus (slave)     : requester handshake, result, flags, busy
//   alu_op_o/a/b    : to the ALU, always from the latched registers
//   alu_out_i, alu_zero_i, alu_neg_i, alu_ovf_i : from the ALU
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int WORD_W = 32
) (
    input  logic                CLK,
    input  logic                nRST,
    alu_arbiter_if.slave        bus,
    output logic [ALUOP_W-1:0]  alu_op_o,
    output logic [WORD_W-1:0]   alu_a_o,
    output logic [WORD_W-1:0]   alu_b_o,
    input  logic [WORD_W-1:0]   alu_out_i,
    input  logic                alu_zero_i,
    input  logic                alu_neg_i,
    input  logic                alu_ovf_i
);

    localparam int IDX_W = idx_w(NREQ);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   gnt_q;
    logic [ALUOP_W-1:0] op_q;
    logic [WORD_W-1:0]  a_q, b_q, result_q;
    logic               zero_q, neg_q, ovf_q;

    logic [NREQ-1:0]    pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               latch_en, capture_en, busy_w;
    logic [NREQ-1:0]    ack_w;

`ifdef ALU_ARB_ROUNDROBIN_EN
    logic [IDX_W-1:0]   rr_q;

    // Reset value NREQ-1 makes requester 0 the first search candidate.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr_q <= IDX_W'(NREQ - 1);
        end else if (latch_en) begin
            rr_q <= pick_idx;
        end
    end
`endif

    alu_arbiter_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_i   (bus.req_i),
`ifdef ALU_ARB_ROUNDROBIN_EN
        .ptr_i   (rr_q),
`endif
        .grant_o (pick_gnt),
        .idx_o   (pick_idx)
    );

    assign pick_any = |pick_gnt;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        latch_en   = 1'b0;
        capture_en = 1'b0;
        busy_w     = 1'b0;
        ack_w      = '0;
        case (state_q)
            IDLE: latch_en = pick_any;
            EXEC: begin
                capture_en = 1'b1;
                busy_w     = 1'b1;
            end
            RESP: begin
                busy_w       = 1'b1;
                ack_w[gnt_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand latch and result capture. Requester inputs are only looked at
    // in IDLE; later changes on them cannot disturb an op in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            gnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (latch_en) begin
                gnt_q <= pick_idx;
                op_q  <= bus.op_i[pick_idx];
                a_q   <= bus.a_i[pick_idx];
                b_q   <= bus.b_i[pick_idx];
            end
            if (capture_en) begin
                result_q <= alu_out_i;
                zero_q   <= alu_zero_i;
                neg_q    <= alu_neg_i;
                ovf_q    <= alu_ovf_i;
            end
        end
    end

    assign alu_op_o       = op_q;
    assign alu_a_o        = a_q;
    assign alu_b_o        = b_q;
    assign bus.ack_o      = ack_w;
    assign bus.busy_o     = busy_w;
    assign bus.result_o   = result_q;
    assign bus.zero_o     = zero_q;
    assign bus.negative_o = neg_q;
    assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int NREQ   = 2;
    localparam int WORD_W = 32;

    logic              CLK;
    logic              nRST;
    logic [3:0]        alu_op;
    logic [WORD_W-1:0] alu_a, alu_b, alu_out;
    logic              alu_zero, alu_neg, alu_ovf;

    alu_arbiter_if #(.NREQ(NREQ), .WORD_W(WORD_W)) bus ();

    alu_arbiter #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .bus        (bus),
        .alu_op_o   (alu_op),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_out_i  (alu_out),
        .alu_zero_i (alu_zero),
        .alu_neg_i  (alu_neg),
        .alu_ovf_i  (alu_ovf)
    );

    // Stand-in for alu_file
    always_comb begin
        alu_out = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                alu_out = alu_a + alu_b;
                alu_ovf = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            ALU_SUB: begin
                alu_out = alu_a - alu_b;
                alu_ovf = (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
            end
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_NOR:  alu_out = ~(alu_a | alu_b);
            ALU_SLL:  alu_out = alu_a << alu_b[4:0];
            ALU_SRL:  alu_out = alu_a >> alu_b[4:0];
            ALU_SLT:  alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU: alu_out = {31'd0, alu_a < alu_b};
            default:  alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
        alu_neg  = alu_out[31];
    end

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int ack_cnt = 0;
    int ack_cyc [NREQ];

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    exp_t exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic push_exp(input int id, input logic [31:0] res,
                            input logic z, input logic n, input logic v);
        exp_t e;
        e.id = id; e.res = res; e.z = z; e.n = n; e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int id, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        bus.op_i[id]  = op;
        bus.a_i[id]   = a;
        bus.b_i[id]   = b;
        bus.req_i[id] = 1'b1;
    endtask

    // Drive a request (while idle), then check the ALU side during EXEC.
    task automatic drive_exec(input string tag, input int id, input logic [3:0] op,
                              input logic [31:0] a, input logic [31:0] b,
                              output int c0);
        drive(id, op, a, b);
        c0 = cyc;
        @(posedge CLK);
        @(negedge CLK);
        check_eq({tag, "_busy"}, bus.busy_o, 1'b1);
        check_eq({tag, "_aluop"}, alu_op, op);
        check_eq({tag, "_alua"}, alu_a, a);
        check_eq({tag, "_alub"}, alu_b, b);
    endtask

    // Wait (bounded) for this requester's ack, then drop req on the edge ending it.
    task automatic wait_ack(input string tag, input int id);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.ack_o[id]) break;
        end
        check_eq({tag, "_ackseen"}, bus.ack_o[id], 1'b1);
        @(posedge CLK);
        #1;
        bus.req_i[id] = 1'b0;
    endtask

    task automatic do_reset();
        bus.req_i = '0;
        nRST = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    // Cycle counter and scoreboard monitor
    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial forever begin
        @(negedge CLK);
        if (bus.ack_o != '0) begin
            int   gid;
            exp_t e;
            gid = 0;
            for (int i = 0; i < NREQ; i++) if (bus.ack_o[i]) gid = i;
            ack_cnt++;
            ack_cyc[gid] = cyc;
            check_eq("ack_onehot", $countones(bus.ack_o), 1);
            check_eq("sb_pending", (exp_q.size() > 0), 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("ack_id", gid, e.id);
                check_eq("result", bus.result_o, e.res);
                check_eq("zero", bus.zero_o, e.z);
                check_eq("negative", bus.negative_o, e.n);
                check_eq("overflow", bus.overflow_o, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        bus.req_i = '0;
        bus.op_i  = '0;
        bus.a_i   = '0;
        bus.b_i   = '0;
        nRST      = 1'b0;
        do_reset();

        // Reset state
        check_eq("rst_ack", bus.ack_o, 0);
        check_eq("rst_busy", bus.busy_o, 0);
        check_eq("rst_result", bus.result_o, 0);
        check_eq("rst_zero", bus.zero_o, 0);
        check_eq("rst_neg", bus.negative_o, 0);
        check_eq("rst_ovf", bus.overflow_o, 0);
        check_eq("rst_aluop", alu_op, 0);
        check_eq("rst_alua", alu_a, 0);

        // 1: basic add and latency
        @(posedge CLK); #1;
        push_exp(0, 32'd12, 1'b0, 1'b0, 1'b0);
        drive_exec("t1", 0, ALU_ADD, 32'd5, 32'd7, c0);
        for (int k = 0; k < 10; k++) begin
            if (bus.ack_o[0]) break;
            @(negedge CLK);
        end
        check_eq("t1_latency", cyc - c0 + 1, 3);
        @(posedge CLK); #1;
        bus.req_i[0] = 1'b0;
        // ALU operands stay on the latched values while idle
        bus.a_i[0] = 32'd999;
        bus.op_i[0] = ALU_SUB;
        @(negedge CLK);
        check_eq("t1_idle_alua", alu_a, 32'd5);
        check_eq("t1_idle_aluop", alu_op, ALU_ADD);
        check_eq("t1_idle_busy", bus.busy_o, 0);

        // 2: signed overflow, then zero result
        @(posedge CLK); #1;
        push_exp(0, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        drive_exec("t2a", 0, ALU_ADD, 32'h7FFF_FFFF, 32'd1, c0);
        wait_ack("t2a", 0);
        push_exp(1, 32'd0, 1'b1, 1'b0, 1'b0);
        drive_exec("t2b", 1, ALU_SUB, 32'd3, 32'd3, c0);
        wait_ack("t2b", 1);

        // 4: signed vs unsigned compare
        push_exp(1, 32'd1, 1'b0, 1'b0, 1'b0);
        drive_exec("t4a", 1, ALU_SLT, 32'hFFFF_FFFF, 32'd1, c0);
        wait_ack("t4a", 1);
        push_exp(1, 32'd0, 1'b1, 1'b0, 1'b0);
        drive_exec("t4b", 1, ALU_SLTU, 32'hFFFF_FFFF, 32'd1, c0);
        wait_ack("t4b", 1);

        // Undefined op code passes through; ALU returns 0
        push_exp(0, 32'd0, 1'b1, 1'b0, 1'b0);
        drive_exec("undef", 0, 4'hF, 32'd5, 32'd9, c0);
        wait_ack("undef", 0);

        // 6a: req0 raised while req1 is in RESP
        push_exp(1, 32'd30, 1'b0, 1'b0, 1'b0);
        push_exp(0, 32'd42, 1'b0, 1'b0, 1'b0);
        drive(1, ALU_ADD, 32'd10, 32'd20);
        @(posedge CLK);
        @(posedge CLK); #1;
        check_eq("t6_resp_ack1", bus.ack_o, 2'b10);
        drive(0, ALU_SUB, 32'd50, 32'd8);
        wait_ack("t6a1", 1);
        wait_ack("t6a0", 0);
        check_eq("t6_gap", ack_cyc[0] - ack_cyc[1], 3);

        // 6b: one-cycle req pulse still completes with latched values
        push_exp(1, 32'h0000_F0F0, 1'b0, 1'b0, 1'b0);
        drive(1, ALU_XOR, 32'h0000_FF00, 32'h0000_0FF0);
        @(posedge CLK); #1;
        bus.req_i[1] = 1'b0;
        bus.op_i[1]  = ALU_ADD;
        bus.a_i[1]   = 32'hDEAD_BEEF;
        wait_ack("t6b", 1);

        // 5: reset during EXEC drops the op; req0 still high gets a fresh op
        push_exp(0, 32'hFFFF_FFFA, 1'b0, 1'b1, 1'b0);
        drive_exec("t5pre", 0, ALU_ADD, 32'hFFFF_FFF8, 32'd2, c0);
        wait_ack("t5pre", 0);
        drive_exec("t5", 0, ALU_ADD, 32'd1, 32'd1, c0);
        nRST = 1'b0;
        #1;
        check_eq("t5_ack", bus.ack_o, 0);
        check_eq("t5_busy", bus.busy_o, 0);
        check_eq("t5_result", bus.result_o, 0);
        check_eq("t5_neg", bus.negative_o, 0);
        check_eq("t5_alua", alu_a, 0);
        check_eq("t5_aluop", alu_op, 0);
        @(posedge CLK);
        @(negedge CLK);
        push_exp(0, 32'd2, 1'b0, 1'b0, 1'b0);
        nRST = 1'b1;
        wait_ack("t5post", 0);

        // 3: both requesting continuously from reset
        do_reset();
        @(posedge CLK); #1;
`ifdef ALU_ARB_ROUNDROBIN_EN
        push_exp(0, 32'd2, 1'b0, 1'b0, 1'b0);
        push_exp(1, 32'd7, 1'b0, 1'b0, 1'b0);
        push_exp(0, 32'd2, 1'b0, 1'b0, 1'b0);
        push_exp(1, 32'd7, 1'b0, 1'b0, 1'b0);
`else
        for (int k = 0; k < 4; k++) push_exp(0, 32'd2, 1'b0, 1'b0, 1'b0);
`endif
        base = ack_cnt;
        drive(0, ALU_ADD, 32'd1, 32'd1);
        drive(1, ALU_SUB, 32'd10, 32'd3);
        for (int k = 0; k < 60; k++) begin
            @(negedge CLK);
            #1;
            if (ack_cnt >= base + 4) break;
        end
        check_eq("t3_acks", ack_cnt - base, 4);
        @(posedge CLK); #1;
        bus.req_i = '0;

        repeat (4) @(negedge CLK);
        check_eq("sb_empty", exp_q.size(), 0);
        check_eq("end_busy", bus.busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
